// File: rtl/sim_run_ctrl_if.sv
// Run-control bundle between the bench harness (master) and the sequencer (slave).
// The CPU-facing outputs travel on the same bundle so the bench can observe them.
interface sim_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_req;
  logic             step_mode;
  logic             step_req;
  logic             cpu_halted;
  logic             cpu_reset;
  logic             cpu_en;
  logic [CNT_W-1:0] cycle_count;
  logic             done;
  logic             timeout;

  modport master (
    output run_req, step_mode, step_req, cpu_halted,
    input  cpu_reset, cpu_en, cycle_count, done, timeout
  );

  modport slave (
    input  run_req, step_mode, step_req, cpu_halted,
    output cpu_reset, cpu_en, cycle_count, done, timeout
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run-control sequencer: stretches reset into a fixed CPU reset, gates the CPU
// clock-enable for free-run / single-step, counts enabled cycles, stops on halt or budget.
//
// state    | meaning
// RST_HOLD | CPU held in reset for RESET_CYCLES cycles
// IDLE     | CPU out of reset, paused, waiting for run or step
// RUN      | free-running, one enabled cycle per clk
// STEP     | exactly one enabled cycle, then back to IDLE
// DONE     | halted or out of budget, terminal until reset
module sim_run_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 10000,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         reset,
  sim_run_ctrl_if.slave bus
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_VAL   = CNT_W'(MAX_CYCLES);
  localparam bit                BUDGET_ON = (MAX_CYCLES != 0);

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    RUN,
    STEP,
    DONE
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   count;
  logic               timeout_r;
  logic               step_q;
  logic               step_rise;
  logic [CNT_W-1:0]   cnt_inc;
  logic               budget_hit;

  assign step_rise  = bus.step_req & ~step_q;
  assign cnt_inc    = count + CNT_W'(1);
  assign budget_hit = BUDGET_ON && (cnt_inc == MAX_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST_HOLD;
      hold_cnt  <= '0;
      count     <= '0;
      timeout_r <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      step_q <= bus.step_req;
      case (state)
        RST_HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= IDLE;
          else                       hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        IDLE: begin
          if (bus.step_mode && step_rise)        state <= STEP;
          else if (!bus.step_mode && bus.run_req) state <= RUN;
        end
        RUN, STEP: begin
          count <= cnt_inc;
          // Halt outranks the budget so a tie reports a clean finish.
          if (bus.cpu_halted) begin
            state <= DONE;
          end else if (budget_hit) begin
            state     <= DONE;
            timeout_r <= 1'b1;
          end else if (state == STEP || bus.step_mode) begin
            state <= IDLE;
          end
        end
        DONE: ;
        default: state <= RST_HOLD;
      endcase
    end
  end

  assign bus.cpu_reset   = (state == RST_HOLD);
  assign bus.cpu_en      = (state == RUN) || (state == STEP);
  assign bus.done        = (state == DONE);
  assign bus.cycle_count = count;
  assign bus.timeout     = timeout_r;

endmodule
